// File: rtl/fetch_seq.sv
`default_nettype none
// fetch_seq: IDLE/ADDR/WAIT/HOLD/LOAD instruction fetch sequencer with registered outputs.
// Define FETCH_SEQ_TIMEOUT_EN to bound WAIT to WAIT_MAX cycles and enable the sticky ERR flag.
module fetch_seq #(
  parameter int WAIT_MAX = 15
) (
  input  logic       CLK,
  input  logic       CLRn,
  input  logic       RUN,
  input  logic [7:0] PC_Q,
  output logic       PC_IPC,
  output logic       PC_LDn,
  output logic [7:0] PC_D,
  output logic [7:0] MEM_ADDR,
  output logic       MEM_RDn,
  input  logic       MEM_RDY,
  input  logic [7:0] MEM_DATA,
  output logic [7:0] IR,
  output logic       IR_VALID,
  input  logic       IR_ACK,
  input  logic       JMP_REQ,
  input  logic [7:0] JMP_ADDR,
  output logic       ERR
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    LOAD = 3'd4
  } state_t;

  state_t state;
  logic   run_ok;

`ifdef FETCH_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;
  logic       timeout;

  // wait_cnt counts RDY-low WAIT cycles already seen, so the current one is the last allowed
  assign timeout = (wait_cnt == 8'(WAIT_MAX - 1));
  assign run_ok  = RUN & ~err_q;
  assign ERR     = err_q;
`else
  logic unused_wait_max;

  assign unused_wait_max = ^8'(WAIT_MAX);
  assign run_ok          = RUN;
  assign ERR             = 1'b0;
`endif

  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      state    <= IDLE;
      IR       <= 8'h00;
      IR_VALID <= 1'b0;
      MEM_ADDR <= 8'h00;
      MEM_RDn  <= 1'b1;
      PC_IPC   <= 1'b0;
      PC_LDn   <= 1'b1;
      PC_D     <= 8'h00;
`ifdef FETCH_SEQ_TIMEOUT_EN
      err_q    <= 1'b0;
      wait_cnt <= 8'h00;
`endif
    end else begin
      // Both PC strobes are single-cycle pulses; only the entering transition raises them.
      PC_IPC <= 1'b0;
      PC_LDn <= 1'b1;
      case (state)
        IDLE: begin
          if (run_ok) state <= ADDR;
        end
        ADDR: begin
          MEM_ADDR <= PC_Q;
          MEM_RDn  <= 1'b0;
`ifdef FETCH_SEQ_TIMEOUT_EN
          wait_cnt <= 8'h00;
`endif
          state    <= WAIT;
        end
        WAIT: begin
          if (MEM_RDY) begin
            IR       <= MEM_DATA;
            IR_VALID <= 1'b1;
            PC_IPC   <= 1'b1;
            MEM_RDn  <= 1'b1;
            state    <= HOLD;
          end
`ifdef FETCH_SEQ_TIMEOUT_EN
          else if (timeout) begin
            err_q   <= 1'b1;
            MEM_RDn <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        HOLD: begin
          if (IR_ACK) begin
            IR_VALID <= 1'b0;
            if (JMP_REQ) begin
              // The load lands one cycle after the increment, so the jump target wins.
              PC_D   <= JMP_ADDR;
              PC_LDn <= 1'b0;
              state  <= LOAD;
            end else if (RUN) begin
              state <= ADDR;
            end else begin
              state <= IDLE;
            end
          end
        end
        LOAD: begin
          state <= ADDR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// tb_fetch_seq: directed and randomized checks of fetch_seq against a cycle-level behavioural model.
module tb_fetch_seq;
  localparam int WAIT_MAX = 15;
  localparam int P_IDLE = 0, P_ADDR = 1, P_WAIT = 2, P_HOLD = 3, P_LOAD = 4;

  logic       CLK = 1'b0, CLRn = 1'b1, RUN = 1'b0, MEM_RDY = 1'b0;
  logic       IR_ACK = 1'b0, JMP_REQ = 1'b0;
  logic [7:0] PC_Q = 8'h0F, MEM_DATA = 8'h00, JMP_ADDR = 8'h00;
  logic       PC_IPC, PC_LDn, MEM_RDn, IR_VALID, ERR;
  logic [7:0] PC_D, MEM_ADDR, IR;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  fetch_seq #(.WAIT_MAX(WAIT_MAX)) dut (
    .CLK(CLK), .CLRn(CLRn), .RUN(RUN), .PC_Q(PC_Q),
    .PC_IPC(PC_IPC), .PC_LDn(PC_LDn), .PC_D(PC_D),
    .MEM_ADDR(MEM_ADDR), .MEM_RDn(MEM_RDn), .MEM_RDY(MEM_RDY), .MEM_DATA(MEM_DATA),
    .IR(IR), .IR_VALID(IR_VALID), .IR_ACK(IR_ACK),
    .JMP_REQ(JMP_REQ), .JMP_ADDR(JMP_ADDR), .ERR(ERR)
  );

  // Rising edges at 2, 12, 22 ... so the 5 ns / 20 ns reset events fall between edges.
  initial begin
    #2;
    forever begin
      CLK = 1'b1; #5;
      CLK = 1'b0; #5;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Behavioural model: which step of the fetch protocol is under way, plus captured values.
  int         phase = P_IDLE;
  int         m_cnt = 0;
  bit         m_first = 1'b0, m_err = 1'b0, first_next;
  logic [7:0] m_ir = 8'h00, m_addr = 8'h00, m_pcd = 8'h00, m_pc = 8'h0F;

  always @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      phase = P_IDLE; m_cnt = 0; m_first = 1'b0; m_err = 1'b0;
      m_ir = 8'h00; m_addr = 8'h00; m_pcd = 8'h00; m_pc = 8'h0F;
    end else begin
      first_next = 1'b0;
      // External program counter: loads win, otherwise increments on the strobe.
      if (phase == P_LOAD) m_pc = m_pcd;
      else if (m_first)    m_pc = m_pc + 8'd1;
      case (phase)
        P_IDLE: if (RUN && !m_err) phase = P_ADDR;
        P_ADDR: begin m_addr = PC_Q; m_cnt = 0; phase = P_WAIT; end
        P_WAIT: begin
          if (MEM_RDY) begin
            m_ir = MEM_DATA; first_next = 1'b1; phase = P_HOLD;
          end else begin
`ifdef FETCH_SEQ_TIMEOUT_EN
            m_cnt = m_cnt + 1;
            if (m_cnt == WAIT_MAX) begin m_err = 1'b1; phase = P_IDLE; end
`endif
          end
        end
        P_HOLD: begin
          if (IR_ACK) begin
            if (JMP_REQ) begin m_pcd = JMP_ADDR; phase = P_LOAD; end
            else phase = RUN ? P_ADDR : P_IDLE;
          end
        end
        default: phase = P_ADDR;
      endcase
      m_first = first_next;
    end
  end

  always @(negedge CLK) PC_Q <= m_pc;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (chk_en) begin
        chk("m.MEM_RDn",  8'(MEM_RDn),  8'(phase != P_WAIT));
        chk("m.IR_VALID", 8'(IR_VALID), 8'(phase == P_HOLD));
        chk("m.PC_LDn",   8'(PC_LDn),   8'(phase != P_LOAD));
        chk("m.PC_IPC",   8'(PC_IPC),   8'(m_first));
        chk("m.ERR",      8'(ERR),      8'(m_err));
        chk("m.IR",       IR,           m_ir);
        chk("m.MEM_ADDR", MEM_ADDR,     m_addr);
        chk("m.PC_D",     PC_D,         m_pcd);
      end
    end
  end

  task automatic at_pos(); @(posedge CLK); #1; endtask
  task automatic at_neg(); @(negedge CLK); endtask

  // which: 0 waits for MEM_RDn low, 1 waits for IR_VALID high.
  task automatic wait_for(input int which, input int budget);
    int k = 0;
    while (((which == 0) ? (MEM_RDn !== 1'b0) : (IR_VALID !== 1'b1)) && k < budget) begin
      at_pos(); k++;
    end
    n_vec++;
    if ((which == 0) ? (MEM_RDn !== 1'b0) : (IR_VALID !== 1'b1)) begin
      n_err++;
      $display("FAIL wait_%0d: condition not met within %0d cycles, got timeout, expected event", which, budget);
    end
  endtask

  initial begin
    int pulses, lds;
    logic [7:0] saved_ir;

    // Reset asserted between edges must force every output at once.
    #5 CLRn = 1'b0;
    #1;
    chk("rst.IR", IR, 8'h00);           chk("rst.IR_VALID", 8'(IR_VALID), 8'h00);
    chk("rst.MEM_ADDR", MEM_ADDR, 8'h00); chk("rst.MEM_RDn", 8'(MEM_RDn), 8'h01);
    chk("rst.PC_IPC", 8'(PC_IPC), 8'h00); chk("rst.PC_LDn", 8'(PC_LDn), 8'h01);
    chk("rst.PC_D", PC_D, 8'h00);       chk("rst.ERR", 8'(ERR), 8'h00);
    chk_en = 1'b1;
    RUN = 1'b1; MEM_RDY = 1'b1; MEM_DATA = 8'hA5; IR_ACK = 1'b1;
    #14 CLRn = 1'b1;

    // Sequential fetch from 0Fh; IR_VALID appears on the third edge counting the RUN sample.
    at_pos(); chk("seq.rdn_addr", 8'(MEM_RDn), 8'h01); chk("seq.valid_addr", 8'(IR_VALID), 8'h00);
    at_pos(); chk("seq.rdn_wait", 8'(MEM_RDn), 8'h00); chk("seq.mem_addr", MEM_ADDR, 8'h0F);
    at_pos(); chk("seq.valid", 8'(IR_VALID), 8'h01); chk("seq.ir", IR, 8'hA5);
    chk("seq.ipc", 8'(PC_IPC), 8'h01);
    pulses = 0; lds = 0;
    for (int i = 0; i < 9; i++) begin
      at_pos();
      if (PC_IPC === 1'b1) pulses++;
      if (PC_LDn === 1'b0) lds++;
    end
    chk("seq.ipc_per_9", 8'(pulses), 8'd3);
    chk("seq.ldn_count", 8'(lds), 8'd0);

    // Jump acknowledged in HOLD.
    at_neg(); IR_ACK = 1'b0;
    wait_for(1, 10);
    at_neg(); IR_ACK = 1'b1; JMP_REQ = 1'b1; JMP_ADDR = 8'h40;
    at_pos(); chk("jmp.ldn", 8'(PC_LDn), 8'h00); chk("jmp.pc_d", PC_D, 8'h40);
    chk("jmp.ipc", 8'(PC_IPC), 8'h00);
    at_neg(); IR_ACK = 1'b0; JMP_REQ = 1'b0; JMP_ADDR = 8'h99;
    at_pos(); chk("jmp.ldn_release", 8'(PC_LDn), 8'h01);
    at_pos(); chk("jmp.mem_addr", MEM_ADDR, 8'h40); chk("jmp.rdn", 8'(MEM_RDn), 8'h00);

    // Backpressure: instruction held while unacknowledged, no new read.
    at_pos(); chk("bp.valid", 8'(IR_VALID), 8'h01);
    saved_ir = IR;
    for (int i = 0; i < 5; i++) begin
      at_pos();
      chk("bp.ir_stable", IR, saved_ir);
      chk("bp.valid_stable", 8'(IR_VALID), 8'h01);
      chk("bp.no_read", 8'(MEM_RDn), 8'h01);
    end
    at_neg(); IR_ACK = 1'b1;
    at_pos(); chk("bp.ack_clears", 8'(IR_VALID), 8'h00);
    at_pos(); chk("bp.next_read", 8'(MEM_RDn), 8'h00);

    // Reset in the middle of WAIT.
    at_neg(); MEM_RDY = 1'b0;
    wait_for(0, 10);
    #2 CLRn = 1'b0;
    #1;
    chk("mid.rdn", 8'(MEM_RDn), 8'h01); chk("mid.ipc", 8'(PC_IPC), 8'h00);
    chk("mid.valid", 8'(IR_VALID), 8'h00);
    MEM_RDY = 1'b1;
    #9 CLRn = 1'b1;

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      at_neg();
      RUN      = ($urandom_range(0, 3) != 0);
      MEM_RDY  = ($urandom_range(0, 1) != 0);
      IR_ACK   = ($urandom_range(0, 1) != 0);
      JMP_REQ  = ($urandom_range(0, 3) == 0);
      MEM_DATA = 8'($urandom);
      JMP_ADDR = 8'($urandom);
    end

`ifdef FETCH_SEQ_TIMEOUT_EN
    at_neg(); #2 CLRn = 1'b0; #2 CLRn = 1'b1;
    RUN = 1'b1; MEM_RDY = 1'b0; IR_ACK = 1'b1; JMP_REQ = 1'b0;
    for (int i = 0; i < 16; i++) at_pos();
    chk("to.err_before", 8'(ERR), 8'h00); chk("to.rdn_before", 8'(MEM_RDn), 8'h00);
    at_pos();
    chk("to.err", 8'(ERR), 8'h01); chk("to.rdn", 8'(MEM_RDn), 8'h01);
    at_neg(); MEM_RDY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      at_pos();
      chk("to.run_ignored", 8'(MEM_RDn), 8'h01);
      chk("to.sticky", 8'(ERR), 8'h01);
    end
    at_neg(); #2 CLRn = 1'b0; #2 CLRn = 1'b1;
    #1 chk("to.cleared", 8'(ERR), 8'h00);
`else
    at_neg(); RUN = 1'b1; MEM_RDY = 1'b0; IR_ACK = 1'b1; JMP_REQ = 1'b0;
    for (int i = 0; i < 40; i++) at_pos();
    chk("nto.rdn_held", 8'(MEM_RDn), 8'h00);
    chk("nto.err_zero", 8'(ERR), 8'h00);
    at_neg(); MEM_RDY = 1'b1;
`endif

    for (int i = 0; i < 4; i++) at_pos();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
